// File: rtl/cpu_defs.sv
// Definitions shared by the CPU core and its data-memory arbiter:
// bus widths, arbiter state encoding and CPU opcodes.
package cpu_defs;

    localparam int CPU_AW = 8;
    localparam int CPU_DW = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOST  = 2'd2
    } arb_state_e;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_LD  = 4'h3;
    localparam logic [3:0] OP_ST  = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;

endpackage

// File: rtl/dmem_mux.sv
// Combinational 2:1 selection of the data-RAM address/data/write strobe
// between the CPU and the host port, with a global write gate.
module dmem_mux #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          sel_host,
    input  logic          we_en,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we
);

    always_comb begin
        if (sel_host) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_we    = we_en & host_we;
        end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = we_en & cpu_we;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: freezes the CPU through its enable pin so the host
// port can run bursts, then guarantees the CPU a minimum run window.
module dmem_arbiter
    import cpu_defs::*;
#(
    parameter int AW        = CPU_AW,
    parameter int DW        = CPU_DW,
    parameter int MAX_BURST = 16,
    parameter int MIN_CPU   = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          sys_enable,
    output logic          cpu_enable,
    input  logic [AW-1:0] cpu_d_addr,
    input  logic [DW-1:0] cpu_d_dataout,
    input  logic          cpu_d_we,
    output logic [DW-1:0] cpu_d_datain,
    input  logic          host_req,
    input  logic          host_valid,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_last,
    output logic          host_gnt,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = $clog2(MIN_CPU + 1);
    localparam int BW = $clog2(MAX_BURST) + 1;

    arb_state_e    state_q, state_d;
    logic [CW-1:0] cool_cnt_q, cool_cnt_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic          cpu_enable_q, cpu_enable_d;
    logic          host_gnt_q, host_gnt_d;
    logic          host_ack_q, host_ack_d;
    logic [DW-1:0] host_rdata_q, host_rdata_d;

    logic beat_acc;
    logic host_start;
    logic host_exit;
    logic sel_host;
    logic we_en;

    assign beat_acc   = (state_q == ST_HOST) && host_valid;
    assign host_start = (state_q == ST_RUN) && host_req && (cool_cnt_q == '0);
    // A forced end at MAX_BURST makes the host go back through the CPU window.
    assign host_exit  = (state_q == ST_HOST) &&
                        ((beat_acc && (host_last || (beat_cnt_q == BW'(MAX_BURST - 1)))) ||
                         (!host_req && !host_valid));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            cool_cnt_q   <= '0;
            beat_cnt_q   <= '0;
            cpu_enable_q <= 1'b0;
            host_gnt_q   <= 1'b0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cool_cnt_q   <= cool_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            cpu_enable_q <= cpu_enable_d;
            host_gnt_q   <= host_gnt_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (host_start) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_HOST;
            ST_HOST:  if (host_exit) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        cpu_enable_d = 1'b0;
        host_gnt_d   = 1'b0;
        cool_cnt_d   = cool_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        host_ack_d   = beat_acc;
        host_rdata_d = beat_acc ? mem_rdata : host_rdata_q;
        unique case (state_q)
            ST_RUN: begin
                cpu_enable_d = sys_enable && !host_start;
                if ((cool_cnt_q != '0) && sys_enable) cool_cnt_d = cool_cnt_q - CW'(1);
            end
            ST_DRAIN: begin
                host_gnt_d = 1'b1;
                beat_cnt_d = '0;
            end
            ST_HOST: begin
                host_gnt_d = 1'b1;
                if (beat_acc) beat_cnt_d = beat_cnt_q + BW'(1);
                if (host_exit) begin
                    host_gnt_d   = 1'b0;
                    cpu_enable_d = sys_enable;
                    cool_cnt_d   = CW'(MIN_CPU);
                end
            end
            default: ;
        endcase
    end

    // Writes are blocked during reset and in the DRAIN bubble.
    assign sel_host = (state_q == ST_HOST);
    assign we_en    = reset && (state_q != ST_DRAIN);

    dmem_mux #(
        .AW(AW),
        .DW(DW)
    ) u_dmem_mux (
        .sel_host  (sel_host),
        .we_en     (we_en),
        .cpu_addr  (cpu_d_addr),
        .cpu_wdata (cpu_d_dataout),
        .cpu_we    (cpu_d_we),
        .host_addr (host_addr),
        .host_wdata(host_wdata),
        .host_we   (host_we & host_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we)
    );

    assign cpu_enable   = cpu_enable_q;
    assign host_gnt     = host_gnt_q;
    assign host_ack     = host_ack_q;
    assign host_rdata   = host_rdata_q;
    assign cpu_d_datain = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural RAM and a shadow
// memory model of every transfer the arbiter is expected to complete.
module tb_dmem_arbiter;

    localparam int AW        = 8;
    localparam int DW        = 16;
    localparam int MAX_BURST = 16;
    localparam int MIN_CPU   = 4;

    logic          clock;
    logic          reset;
    logic          sys_enable;
    logic          cpu_enable;
    logic [AW-1:0] cpu_d_addr;
    logic [DW-1:0] cpu_d_dataout;
    logic          cpu_d_we;
    logic [DW-1:0] cpu_d_datain;
    logic          host_req;
    logic          host_valid;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_last;
    logic          host_gnt;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] ram [0:255] = '{default: 16'h0000};
    logic [DW-1:0] model_mem [0:255];

    int n_pass  = 0;
    int n_total = 0;

    dmem_arbiter #(
        .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .MIN_CPU(MIN_CPU)
    ) dut (
        .clock(clock), .reset(reset), .sys_enable(sys_enable), .cpu_enable(cpu_enable),
        .cpu_d_addr(cpu_d_addr), .cpu_d_dataout(cpu_d_dataout), .cpu_d_we(cpu_d_we),
        .cpu_d_datain(cpu_d_datain), .host_req(host_req), .host_valid(host_valid),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_last(host_last), .host_gnt(host_gnt), .host_ack(host_ack),
        .host_rdata(host_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) if (mem_we) ram[mem_addr] <= mem_wdata;
    assign mem_rdata = ram[mem_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } host_vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_d_addr = a;
        cpu_d_dataout = d;
        cpu_d_we = 1'b1;
        model_mem[a] = d;
        step();
        cpu_d_we = 1'b0;
    endtask

    task automatic wait_gnt(output int lat);
        host_req = 1'b1;
        host_valid = 1'b0;
        lat = 0;
        while (!host_gnt && lat < 40) begin
            step();
            lat++;
        end
        chk("gnt_within_bound", host_gnt, 1'b1);
    endtask

    task automatic release_host();
        host_req = 1'b0;
        host_valid = 1'b0;
        host_last = 1'b0;
        step();
    endtask

    // Continuous-valid burst starting at grant: the first min(n, MAX_BURST)
    // beats complete in order, anything after that is ignored.
    task automatic burst(input int n, input logic we, input logic [AW-1:0] base, output int acks);
        int n_acc;
        logic [DW-1:0] exp_rd;
        logic [DW-1:0] wd;
        n_acc = (n < MAX_BURST) ? n : MAX_BURST;
        acks = 0;
        exp_rd = '0;
        for (int i = 0; i < n; i++) begin
            wd = DW'($urandom);
            host_valid = 1'b1;
            host_we = we;
            host_addr = base + AW'(i);
            host_wdata = wd;
            host_last = (i == n - 1);
            if (i < n_acc) begin
                exp_rd = model_mem[host_addr];
                if (we) model_mem[host_addr] = wd;
            end
            step();
            if (i < n_acc) begin
                chk("burst_ack", host_ack, 1'b1);
                chk("burst_rdata", host_rdata, exp_rd);
                if (host_ack) acks++;
                if (i == n_acc - 1) chk("burst_gnt_drop", host_gnt, 1'b0);
            end else begin
                chk("burst_extra_noack", host_ack, 1'b0);
            end
        end
        host_valid = 1'b0;
        host_last = 1'b0;
    endtask

    host_vec_t vecs [6];
    int lat;
    int acks;
    int nbad;

    initial begin
        vecs[0] = '{1'b0, 8'h05, 16'h0000, 16'h1111};
        vecs[1] = '{1'b1, 8'h30, 16'h1234, 16'h0000};
        vecs[2] = '{1'b0, 8'h30, 16'h0000, 16'h1234};
        vecs[3] = '{1'b1, 8'h30, 16'hBEEF, 16'h1234};
        vecs[4] = '{1'b0, 8'h30, 16'h0000, 16'hBEEF};
        vecs[5] = '{1'b0, 8'h10, 16'h0000, 16'hABCD};
        for (int i = 0; i < 256; i++) model_mem[i] = '0;

        reset = 1'b0;
        sys_enable = 1'b1;
        cpu_d_addr = 8'h05;
        cpu_d_dataout = 16'h3333;
        cpu_d_we = 1'b1;
        host_req = 1'b0; host_valid = 1'b0; host_we = 1'b0;
        host_addr = '0; host_wdata = '0; host_last = 1'b0;

        // reset values, and the CPU store is held off until reset releases
        #2;
        chk("rst_cpu_enable", cpu_enable, 1'b0);
        chk("rst_host_gnt", host_gnt, 1'b0);
        chk("rst_host_ack", host_ack, 1'b0);
        chk("rst_host_rdata", host_rdata, 16'h0);
        chk("rst_mem_we", mem_we, 1'b0);
        #18 reset = 1'b1;
        step();
        model_mem[8'h05] = 16'h3333;
        cpu_d_we = 1'b0;
        chk("cpu_enable_after_rst", cpu_enable, 1'b1);
        chk("cpu_store_3333", ram[8'h05], 16'h3333);

        // single host write, cycle by cycle
        host_req = 1'b1; host_valid = 1'b1; host_we = 1'b1;
        host_addr = 8'h10; host_wdata = 16'hABCD; host_last = 1'b1;
        step();
        chk("drain_cpu_enable", cpu_enable, 1'b0);
        chk("drain_gnt", host_gnt, 1'b0);
        chk("drain_mem_we", mem_we, 1'b0);
        step();
        chk("host_gnt_2cyc", host_gnt, 1'b1);
        chk("host_mem_we", mem_we, 1'b1);
        chk("host_mem_addr", mem_addr, 8'h10);
        step();
        model_mem[8'h10] = 16'hABCD;
        chk("wr_ack", host_ack, 1'b1);
        chk("wr_gnt_drop", host_gnt, 1'b0);
        chk("wr_cpu_resume", cpu_enable, 1'b1);
        chk("wr_landed", ram[8'h10], 16'hABCD);
        host_req = 1'b0; host_valid = 1'b0; host_last = 1'b0;
        step();
        chk("wr_ack_single_pulse", host_ack, 1'b0);

        // table of single-beat host accesses after a CPU store of 1111
        cpu_store(8'h05, 16'h1111);
        for (int v = 0; v < 6; v++) begin
            wait_gnt(lat);
            host_valid = 1'b1; host_we = vecs[v].we; host_addr = vecs[v].addr;
            host_wdata = vecs[v].wdata; host_last = 1'b1;
            step();
            if (vecs[v].we) model_mem[vecs[v].addr] = vecs[v].wdata;
            chk("vec_ack", host_ack, 1'b1);
            chk("vec_rdata", host_rdata, vecs[v].exp_rdata);
            chk("vec_cpu_enable", cpu_enable, 1'b1);
            release_host();
        end

        // 20-beat burst truncated at MAX_BURST, req held for re-grant
        repeat (MIN_CPU + 1) step();
        wait_gnt(lat);
        burst(20, 1'b1, 8'h60, acks);
        chk("burst20_acks", acks, MAX_BURST);
        wait_gnt(lat);
        chk("regrant_gap", (20 - MAX_BURST) + lat, MIN_CPU + 2);
        release_host();

        // CPU store in the transition cycle
        repeat (MIN_CPU + 1) step();
        cpu_d_addr = 8'h22; cpu_d_dataout = 16'h5A5A; cpu_d_we = 1'b1;
        host_req = 1'b1; host_valid = 1'b0;
        step();
        model_mem[8'h22] = 16'h5A5A;
        chk("trans_store_landed", ram[8'h22], 16'h5A5A);
        chk("trans_drain_mem_we", mem_we, 1'b0);
        cpu_d_we = 1'b0;
        step();
        chk("trans_gnt", host_gnt, 1'b1);
        host_valid = 1'b1; host_we = 1'b0; host_addr = 8'h22; host_last = 1'b1;
        step();
        chk("trans_rd_ack", host_ack, 1'b1);
        chk("trans_rdata", host_rdata, 16'h5A5A);
        release_host();

        // sys_enable low freezes the CPU window counter
        wait_gnt(lat);
        host_valid = 1'b1; host_we = 1'b1; host_addr = 8'h35; host_wdata = 16'h7777; host_last = 1'b1;
        step();
        model_mem[8'h35] = 16'h7777;
        chk("sysen_wr_ack", host_ack, 1'b1);
        sys_enable = 1'b0;
        host_valid = 1'b0; host_last = 1'b0;
        repeat (8) step();
        chk("sysen_no_gnt", host_gnt, 1'b0);
        chk("sysen_cpu_off", cpu_enable, 1'b0);
        sys_enable = 1'b1;
        wait_gnt(lat);
        chk("sysen_regrant_lat", lat, MIN_CPU + 2);
        chk("sysen_host_cpu_off", cpu_enable, 1'b0);
        release_host();
        step();
        chk("sysen_cpu_resume", cpu_enable, 1'b1);

        // asynchronous reset during beat 3 of a write burst
        repeat (MIN_CPU + 1) step();
        wait_gnt(lat);
        for (int i = 0; i < 3; i++) begin
            host_valid = 1'b1; host_we = 1'b1; host_addr = 8'h40 + AW'(i);
            host_wdata = 16'hC000 + DW'(i); host_last = 1'b0;
            model_mem[host_addr] = host_wdata;
            step();
            chk("rb_ack", host_ack, 1'b1);
        end
        host_addr = 8'h43; host_wdata = 16'hC003;
        #2 reset = 1'b0;
        #1;
        chk("rb_gnt_async", host_gnt, 1'b0);
        chk("rb_ack_async", host_ack, 1'b0);
        chk("rb_cpu_en_async", cpu_enable, 1'b0);
        chk("rb_mem_we_async", mem_we, 1'b0);
        step();
        reset = 1'b1;
        host_req = 1'b0;
        for (int i = 4; i < 6; i++) begin
            host_addr = 8'h40 + AW'(i);
            step();
            chk("rb_after_noack", host_ack, 1'b0);
            chk("rb_after_nognt", host_gnt, 1'b0);
        end
        chk("rb_cpu_en_after", cpu_enable, 1'b1);
        chk("rb_beat3_dropped", ram[8'h43], model_mem[8'h43]);
        host_valid = 1'b0;

        // randomized mix of CPU stores and host bursts
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                cpu_store(AW'($urandom_range(128, 239)), DW'($urandom));
            end else begin
                int n;
                n = $urandom_range(1, 20);
                wait_gnt(lat);
                burst(n, 1'($urandom), AW'($urandom_range(128, 224)), acks);
                chk("rand_acks", acks, (n < MAX_BURST) ? n : MAX_BURST);
                release_host();
            end
        end

        nbad = 0;
        for (int a = 0; a < 256; a++) if (ram[a] !== model_mem[a]) nbad++;
        chk("mem_sweep_mismatches", nbad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
